// File: rtl/mac_dot_sequencer_pkg.sv
// Shared types and constants for the MAC dot-product sequencer.
package mac_dot_sequencer_pkg;

    localparam int unsigned OPND_W  = 8;   // MAC operand width
    localparam int unsigned PROD_W  = 16;  // MAC product width
    localparam int unsigned MAC_LAT = 2;   // mac_en -> mac_done latency of the MAC

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Job, operand-memory and MAC signals of the dot-product sequencer.
interface mac_dot_sequencer_if
    import mac_dot_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ACC_W  = 24
);

    // job request / report
    logic              start;
    logic              abort;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
    logic              sat;

    // operand memories
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [OPND_W-1:0] rd_data_a;
    logic [OPND_W-1:0] rd_data_b;

    // MAC pipeline
    logic              mac_en;
    logic [OPND_W-1:0] mac_a;
    logic [OPND_W-1:0] mac_b;
    logic [PROD_W-1:0] mac_result;
    logic              mac_done;

    // sequencer side
    modport master (
        input  start, abort, len, base_a, base_b,
        output busy, done, result, sat,
        output rd_en, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b,
        output mac_en, mac_a, mac_b,
        input  mac_result, mac_done
    );

    // layer controller, memories and MAC side
    modport slave (
        output start, abort, len, base_a, base_b,
        input  busy, done, result, sat,
        input  rd_en, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b,
        input  mac_en, mac_a, mac_b,
        output mac_result, mac_done
    );

endinterface

// File: rtl/mac_dot_sequencer_accumulator.sv
// Saturating ACC_W accumulator with sticky overflow flag.
module mac_sat_accumulator
    import mac_dot_sequencer_pkg::*;
#(
    parameter int unsigned ACC_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  acc_next_c,
    output logic              sat_next_c
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] acc;
    logic             sat;
    logic [SUM_W-1:0] sum_c;

    // next accumulator value: clear wins, otherwise clamp on carry-out
    always_comb begin
        sum_c      = SUM_W'(acc) + SUM_W'(addend);
        acc_next_c = acc;
        sat_next_c = sat;
        if (clear) begin
            acc_next_c = '0;
            sat_next_c = 1'b0;
        end else if (en) begin
            if (sum_c[ACC_W]) begin
                acc_next_c = '1;
                sat_next_c = 1'b1;
            end else begin
                acc_next_c = sum_c[ACC_W-1:0];
            end
        end
    end

    // accumulator and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            sat <= 1'b0;
        end else begin
            acc <= acc_next_c;
            sat <= sat_next_c;
        end
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Sequences operand fetches into the MAC and accumulates one dot product per job.
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ACC_W  = 24
) (
    input  logic                clk,
    input  logic                rst,
    mac_dot_sequencer_if.master bus
);

    seq_state_e        state;
    seq_state_e        state_next;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_next;
    logic [LEN_W-1:0]  len_m1_c;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  issue_next;
    logic [LEN_W-1:0]  done_cnt;
    logic [LEN_W-1:0]  done_cnt_next;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_a_next;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_b_next;

    logic              rd_en_q;
    logic              rd_en_next;
    logic              mac_en_q;
    logic              mac_en_next;
    logic              busy_q;
    logic              busy_next;
    logic              done_q;
    logic              done_next;
    logic [ACC_W-1:0]  result_q;
    logic [ACC_W-1:0]  result_next;
    logic              sat_q;
    logic              sat_next;

    logic              mac_ok_c;
    logic              abort_hit_c;
    logic              acc_clear_c;
    logic              acc_en_c;
    logic [ACC_W-1:0]  acc_next_c;
    logic              acc_sat_next_c;

    // products count only while a job is running; abort drops them
    assign mac_ok_c    = bus.mac_done && ((state == ST_ISSUE) || (state == ST_DRAIN));
    assign abort_hit_c = bus.abort && (state != ST_IDLE);
    assign acc_clear_c = (state == ST_IDLE) && bus.start && !bus.abort;
    assign acc_en_c    = mac_ok_c && !abort_hit_c;
    assign len_m1_c    = len_q - LEN_W'(1);

    mac_sat_accumulator #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear_c),
        .en         (acc_en_c),
        .addend     (bus.mac_result),
        .acc_next_c (acc_next_c),
        .sat_next_c (acc_sat_next_c)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state, counters, addresses and registered outputs
    always_comb begin
        state_next    = state;
        len_next      = len_q;
        issue_next    = issue_cnt;
        done_cnt_next = done_cnt;
        addr_a_next   = addr_a;
        addr_b_next   = addr_b;
        done_next     = 1'b0;
        result_next   = result_q;
        sat_next      = sat_q;

        unique case (state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    len_next      = bus.len;
                    addr_a_next   = bus.base_a;
                    addr_b_next   = bus.base_b;
                    issue_next    = '0;
                    done_cnt_next = '0;
                    state_next    = (bus.len == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mac_ok_c) begin
                    done_cnt_next = done_cnt + LEN_W'(1);
                end
                if (issue_cnt == len_m1_c) begin
                    state_next = ST_DRAIN;
                end else begin
                    issue_next  = issue_cnt + LEN_W'(1);
                    addr_a_next = addr_a + ADDR_W'(1);
                    addr_b_next = addr_b + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (mac_ok_c) begin
                    done_cnt_next = done_cnt + LEN_W'(1);
                end
                // leave as soon as the last product lands so done meets N+2+MAC_LAT
                if (done_cnt_next == len_q) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort_hit_c) begin
            state_next = ST_IDLE;
        end

        // result captured from the accumulator's incoming value on entry to FINISH
        if (state_next == ST_FINISH) begin
            done_next   = 1'b1;
            result_next = acc_next_c;
            sat_next    = acc_sat_next_c;
        end

        rd_en_next  = (state_next == ST_ISSUE);
        mac_en_next = rd_en_q && !abort_hit_c;
        busy_next   = (state_next == ST_ISSUE) || (state_next == ST_DRAIN);
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            issue_cnt <= '0;
            done_cnt  <= '0;
            addr_a    <= '0;
            addr_b    <= '0;
            rd_en_q   <= 1'b0;
            mac_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            sat_q     <= 1'b0;
        end else begin
            len_q     <= len_next;
            issue_cnt <= issue_next;
            done_cnt  <= done_cnt_next;
            addr_a    <= addr_a_next;
            addr_b    <= addr_b_next;
            rd_en_q   <= rd_en_next;
            mac_en_q  <= mac_en_next;
            busy_q    <= busy_next;
            done_q    <= done_next;
            result_q  <= result_next;
            sat_q     <= sat_next;
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = addr_a;
    assign bus.rd_addr_b = addr_b;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_a     = bus.rd_data_a;
    assign bus.mac_b     = bus.rd_data_b;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.sat       = sat_q;

endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Controller that computes one unsigned dot product of length LEN by sequencing the 2-stage 8x8 MAC pipeline.
- Fetches operand pairs from two read-only operand memories (activation, weight) and feeds the MAC one pair per cycle.
- Accumulates MAC products into a wide accumulator and reports one result per start.
- Sits between the MLP-Mixer layer controller (start/len/base) and the MAC + operand SRAMs.

Parameters:
- ADDR_W, 8, operand memory address width.
- LEN_W, 8, width of length input; max length 2^LEN_W-1.
- ACC_W, 24, accumulator/result width (>=16).
- MAC_LAT, 2, cycles from mac_en to the matching mac_done pulse.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  1-cycle request; sampled only in IDLE
- abort  in  1  cancel current job, no done
- len  in  LEN_W  number of pairs, sampled with start
- base_a  in  ADDR_W  start address, activation memory
- base_b  in  ADDR_W  start address, weight memory
- rd_en  out  1  read strobe to both memories
- rd_addr_a  out  ADDR_W  activation address
- rd_addr_b  out  ADDR_W  weight address
- rd_data_a  in  8  activation data, valid 1 cycle after rd_en
- rd_data_b  in  8  weight data, valid 1 cycle after rd_en
- mac_en  out  1  MAC enable
- mac_a  out  8  MAC operand A
- mac_b  out  8  MAC operand B
- mac_result  in  16  MAC product
- mac_done  in  1  MAC product valid
- busy  out  1  job in progress
- done  out  1  1-cycle pulse, result valid
- result  out  ACC_W  dot product, held until next done
- sat  out  1  accumulator saturated during the job, held with result

Behaviour:
- Reset (sync, rst high at edge): state IDLE; rd_en, mac_en, busy, done, sat = 0; result, acc, counters, addresses = 0. Reset mid-job discards the job; no done.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: on start with len>0, latch len/bases, clear acc/sat/counters, go ISSUE, busy=1. start with len==0 goes to FINISH directly (result 0).
  - ISSUE: rd_en=1 each cycle, addr = base + issue_cnt (wraps modulo 2^ADDR_W). After len reads, go DRAIN.
  - DRAIN: wait until done_cnt == len, then go FINISH.
  - FINISH: done=1 for one cycle, result=acc, sat latched, busy=0, go IDLE.
- Operand path: mac_en is rd_en delayed by one register. mac_a/mac_b = rd_data_a/rd_data_b passed through combinationally, aligned with mac_en.
- Accumulate: on each mac_done, acc += zero-extended mac_result and done_cnt++.
  - Saturating: if the sum would exceed 2^ACC_W-1, acc = all ones and sat=1.
  - mac_done in IDLE/FINISH is ignored.
- Timing, start sampled at cycle 0, len=N:
  - rd_en in cycles 1..N
  - mac_en in cycles 2..N+1
  - mac_done in cycles 2+MAC_LAT..N+1+MAC_LAT
  - done in cycle N+2+MAC_LAT (N+4 for default)
- Throughput: one pair/cycle, no bubbles. Next start is accepted the cycle after done.
- start while busy: ignored, no effect on latched len/bases.
- abort (any non-IDLE state): next cycle IDLE, rd_en=0, mac_en=0, busy=0, no done; result/sat keep previous job values. In-flight mac_done pulses after abort are ignored. abort has priority over start in the same cycle.
- rst has priority over abort and start.

Decomposition:
- Shared package: FSM state encoding constants (IDLE/ISSUE/DRAIN/FINISH), default MAC_LAT=2, operand width 8, product width 16.
- One natural sub-module: mac_sat_accumulator (ACC_W saturating adder + sat flag, clear/enable inputs). Keep address counters and FSM in the top.

Test Plan:
- len=4, A=[1,2,3,4], B=[5,6,7,8], start at cycle 0 -> rd_en cycles 1-4, mac_en cycles 2-5, done pulse cycle 8, result=70, sat=0.
- len=0 -> done pulse the cycle after start (FINISH), result=0, no rd_en/mac_en activity.
- ACC_W=16, len=2, A=B=[255,255] -> result=65535, sat=1 (raw sum 130050).
- base_a=254, len=4 -> rd_addr_a sequence 254,255,0,1; result matches the wrapped data.
- Second start pulsed while busy with len=4 -> ignored; exactly one done, result from the first job; a new start the cycle after done is accepted.
- abort in cycle 3 of a len=8 job -> busy=0 and rd_en=0 next cycle, no done, prior result unchanged. rst asserted mid-job -> all outputs 0 next cycle.
